// File: rtl/sobel_pkg.sv
// Shared types and sizes for the Sobel window loader slice.
// Buffer index is 4*row+col; col0 is the oldest column.
package sobel_pkg;
    localparam int PIX_W    = 8;
    localparam int ROWS     = 3;
    localparam int BUF_COLS = 4;
    localparam int BUF_PIX  = ROWS * BUF_COLS;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        CALC,
        ADVANCE
    } loader_state_t;

    typedef logic [BUF_PIX-1:0][PIX_W-1:0] win_buf_t;
    typedef logic [ROWS-1:0][PIX_W-1:0]    column_t;
endpackage

// File: rtl/sobel_window_loader_if.sv
// Pixel stream valid/ready handshake into the window loader.
// The producer drives pixel_in/pixel_valid; the loader drives pixel_ready.
interface sobel_window_loader_if;
    import sobel_pkg::*;

    logic [PIX_W-1:0] pixel_in;
    logic             pixel_valid;
    logic             pixel_ready;

    modport master (
        output pixel_in,
        output pixel_valid,
        input  pixel_ready
    );

    modport slave (
        input  pixel_in,
        input  pixel_valid,
        output pixel_ready
    );
endinterface

// File: rtl/sobel_column_stager.sv
// Collects row0/row1/row2 pixels of one column; o_col_valid marks
// the handshake that carries row2, with the whole column alongside.
module sobel_column_stager
    import sobel_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic             i_accept,
    input  logic [PIX_W-1:0] i_pixel,
    output logic             o_col_valid,
    output column_t          o_col
);
    logic [1:0]       r_row;
    logic [PIX_W-1:0] r_row0;
    logic [PIX_W-1:0] r_row1;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_row  <= 2'd0;
            r_row0 <= '0;
            r_row1 <= '0;
        end else if (i_accept) begin
            unique case (r_row)
                2'd0: begin
                    r_row0 <= i_pixel;
                    r_row  <= 2'd1;
                end
                2'd1: begin
                    r_row1 <= i_pixel;
                    r_row  <= 2'd2;
                end
                default: r_row <= 2'd0;
            endcase
        end
    end

    assign o_col_valid = i_accept && (r_row == 2'd2);
    assign o_col       = {i_pixel, r_row1, r_row0};
endmodule

// File: rtl/sobel_window_loader.sv
// Assembles a 3x4 dual-window buffer from a column-ordered pixel
// stream and pulses enable_calc once per window pair, stride 2.
module sobel_window_loader
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH = 640
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   start,
    sobel_window_loader_if.slave   pix_if,
    output win_buf_t               data_buffer,
    output logic                   enable_calc,
    output logic                   busy,
    output logic                   strip_done
);
    localparam int CNT_W = $clog2(IMG_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_COL  = CNT_W'(IMG_WIDTH);
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(BUF_COLS - 1);

    loader_state_t    r_state;
    loader_state_t    w_next;
    logic [CNT_W-1:0] r_col_cnt;
    win_buf_t         r_buf;
    logic             w_ready;
    logic             w_accept;
    logic             w_col_valid;
    column_t          w_col;
    logic             w_enable;
    logic             w_done;

    assign w_ready            = (r_state == FILL) || (r_state == ADVANCE);
    assign w_accept           = pix_if.pixel_valid && w_ready;
    assign pix_if.pixel_ready = w_ready;

    sobel_column_stager u_stager (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_accept   (w_accept),
        .i_pixel    (pix_if.pixel_in),
        .o_col_valid(w_col_valid),
        .o_col      (w_col)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                        r_col_cnt <= '0;
        else if (r_state == IDLE && start) r_col_cnt <= '0;
        else if (w_col_valid)              r_col_cnt <= r_col_cnt + CNT_W'(1);
    end

    // Every row shifts left by one column; the new column lands in col3
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_buf <= '0;
        end else if (w_col_valid) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < BUF_COLS - 1; c++)
                    r_buf[BUF_COLS*r+c] <= r_buf[BUF_COLS*r+c+1];
                r_buf[BUF_COLS*r+BUF_COLS-1] <= w_col[r];
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        w_enable = 1'b0;
        w_done   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) w_next = FILL;
            end
            FILL: begin
                if (w_col_valid && r_col_cnt == FILL_LAST) w_next = CALC;
            end
            CALC: begin
                w_enable = 1'b1;
                if (r_col_cnt == LAST_COL) begin
                    w_done = 1'b1;
                    w_next = IDLE;
                end else begin
                    w_next = ADVANCE;
                end
            end
            ADVANCE: begin
                // odd count here means this column makes the pair complete
                if (w_col_valid && r_col_cnt[0]) w_next = CALC;
            end
        endcase
    end

    assign data_buffer = r_buf;
    assign enable_calc = w_enable;
    assign strip_done  = w_done;
    assign busy        = (r_state != IDLE);
endmodule

// File: tb/tb_sobel_window_loader.sv
// Self-checking bench for sobel_window_loader with IMG_WIDTH=8.
// Reference model keeps the accepted pixel stream in a queue.
module tb_sobel_window_loader;
    import sobel_pkg::*;

    localparam int W = 8;

    typedef struct {
        int gap;
        bit noise;
        bit seq;
        int exp_pulses;
    } strip_vec_t;

    typedef struct {
        int pulse;
        int idx;
        int val;
    } win_vec_t;

    logic     clk = 1'b0;
    logic     n_rst = 1'b0;
    logic     start = 1'b0;
    win_buf_t data_buffer;
    logic     enable_calc;
    logic     busy;
    logic     strip_done;

    sobel_window_loader_if pif();

    sobel_window_loader #(.IMG_WIDTH(W)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .pix_if     (pif.slave),
        .data_buffer(data_buffer),
        .enable_calc(enable_calc),
        .busy       (busy),
        .strip_done (strip_done)
    );

    always #5 clk = ~clk;

    int       errors = 0;
    int       checks = 0;
    int       acc[$];
    bit       m_busy = 0;
    bit       m_calc = 0;
    bit       m_done = 0;
    int       pulses;
    win_buf_t snap[4];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Window pair = the four most recent complete columns of the stream
    function automatic win_buf_t model_win();
        win_buf_t w;
        int n;
        n = acc.size() / 3;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                w[4*r+c] = PIX_W'(acc[3*(n-4+c)+r]);
        return w;
    endfunction

    task automatic cycle(input bit st, input bit v, input logic [7:0] px);
        bit acc_now;
        int n;
        start = st;
        pif.pixel_valid = v;
        pif.pixel_in = px;
        acc_now = m_busy && !m_calc && v;
        @(posedge clk);
        #1;
        if (!m_busy) begin
            if (st) begin
                acc.delete();
                m_busy = 1;
            end
        end else if (m_done) begin
            m_busy = 0;
        end
        if (acc_now) acc.push_back(int'(px));
        n = acc.size() / 3;
        m_calc = acc_now && (acc.size() % 3 == 0) && n >= 4 && (n % 2 == 0);
        m_done = m_calc && n == W;
        chk("busy", busy, m_busy);
        chk("pixel_ready", pif.pixel_ready, m_busy && !m_calc);
        chk("enable_calc", enable_calc, m_calc);
        chk("strip_done", strip_done, m_done);
        if (m_calc) chk("data_buffer", data_buffer, model_win());
        if (enable_calc) begin
            if (pulses < 4) snap[pulses] = data_buffer;
            pulses++;
        end
    endtask

    task automatic run_strip(input strip_vec_t v, input win_vec_t wv[$]);
        logic [7:0] px;
        int cyc;
        bit vld;
        bit st;
        bit will_acc;
        pulses = 0;
        px = v.seq ? 8'd1 : 8'($urandom);
        cycle(1'b1, 1'b0, 8'd0);
        cyc = 0;
        while (cyc < 2000) begin
            vld = ($urandom_range(99) >= v.gap);
            st = v.noise && (m_calc || $urandom_range(3) == 0);
            will_acc = m_busy && !m_calc && vld;
            cycle(st, vld, px);
            if (will_acc) px = v.seq ? px + 8'd1 : 8'($urandom);
            cyc++;
            if (!m_busy) break;
        end
        if (cyc >= 2000) begin
            errors++;
            checks++;
            $display("FAIL strip_timeout: got %0d cycles required < 2000", cyc);
        end
        chk("pulse_count", pulses, v.exp_pulses);
        if (v.seq)
            foreach (wv[i])
                chk($sformatf("win_p%0d_i%0d", wv[i].pulse, wv[i].idx),
                    snap[wv[i].pulse][wv[i].idx], wv[i].val);
    endtask

    strip_vec_t vecs[4];
    win_vec_t   wv[$];

    initial begin
        vecs[0] = '{gap: 0,  noise: 0, seq: 1, exp_pulses: 3};
        vecs[1] = '{gap: 50, noise: 0, seq: 1, exp_pulses: 3};
        vecs[2] = '{gap: 50, noise: 1, seq: 1, exp_pulses: 3};
        vecs[3] = '{gap: 30, noise: 1, seq: 0, exp_pulses: 3};
        wv = '{
            '{0, 0, 1},  '{0, 1, 4},  '{0, 2, 7},  '{0, 3, 10},
            '{0, 4, 2},  '{0, 5, 5},  '{0, 6, 8},  '{0, 7, 11},
            '{0, 8, 3},  '{0, 9, 6},  '{0, 10, 9}, '{0, 11, 12},
            '{1, 0, 7},  '{1, 1, 10}, '{1, 2, 13}, '{1, 3, 16},
            '{2, 8, 15}, '{2, 9, 18}, '{2, 10, 21}, '{2, 11, 24}
        };
        pif.pixel_valid = 1'b0;
        pif.pixel_in = '0;

        @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", pif.pixel_ready, 1'b0);
        chk("rst_enable", enable_calc, 1'b0);
        chk("rst_buffer", data_buffer, '0);
        n_rst = 1'b1;

        // Abort a strip part-way through its second column
        cycle(1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'(50 + i));
        #3;
        n_rst = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ready", pif.pixel_ready, 1'b0);
        chk("midrst_enable", enable_calc, 1'b0);
        chk("midrst_done", strip_done, 1'b0);
        chk("midrst_buffer", data_buffer, '0);
        acc.delete();
        m_busy = 0;
        m_calc = 0;
        m_done = 0;
        pif.pixel_valid = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;

        for (int s = 0; s < 4; s++) run_strip(vecs[s], wv);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 8'hAA);
        chk("idle_buffer_held", data_buffer, model_win());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
